// File: rtl/bp_fe_lce_responder.sv
`default_nettype none
// ============================================================================
// bp_fe_lce_responder: front-end I-cache miss responder. It fetches the missing
// block from memory and then writes the data, tag and stat arrays.
// Revision: 1.0
// ============================================================================
module bp_fe_lce_responder #(
  parameter int paddr_width_p = 40,
  parameter int lce_sets_p    = 64,
  parameter int lce_assoc_p   = 8,
  parameter int block_width_p = 512,
  parameter int dword_width_p = 64,
  localparam int index_width_lp  = $clog2(lce_sets_p),
  localparam int way_width_lp    = $clog2(lce_assoc_p),
  localparam int offset_width_lp = $clog2(block_width_p/8),
  localparam int tag_width_lp    = paddr_width_p - index_width_lp - offset_width_lp
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [paddr_width_p-1:0]  cache_req_addr_i,
  input  logic                      cache_req_uncached_i,
  input  logic                      cache_req_v_i,
  output logic                      cache_req_ready_o,
  input  logic [way_width_lp-1:0]   cache_req_metadata_way_i,
  input  logic                      cache_req_metadata_v_i,
  output logic                      cache_req_complete_o,

  output logic [paddr_width_p-1:0]  mem_cmd_addr_o,
  output logic                      mem_cmd_v_o,
  input  logic                      mem_cmd_ready_i,
  input  logic [block_width_p-1:0]  mem_resp_data_i,
  input  logic                      mem_resp_v_i,
  output logic                      mem_resp_yumi_o,

  output logic                      data_mem_pkt_uncached_o,
  output logic [index_width_lp-1:0] data_mem_pkt_index_o,
  output logic [way_width_lp-1:0]   data_mem_pkt_way_o,
  output logic [block_width_p-1:0]  data_mem_pkt_data_o,
  output logic                      data_mem_pkt_v_o,
  input  logic                      data_mem_pkt_ready_i,

  output logic [index_width_lp-1:0] tag_mem_pkt_index_o,
  output logic [way_width_lp-1:0]   tag_mem_pkt_way_o,
  output logic [tag_width_lp-1:0]   tag_mem_pkt_tag_o,
  output logic                      tag_mem_pkt_v_o,
  input  logic                      tag_mem_pkt_ready_i,

  output logic [index_width_lp-1:0] stat_mem_pkt_index_o,
  output logic [way_width_lp-1:0]   stat_mem_pkt_way_o,
  output logic                      stat_mem_pkt_v_o,
  input  logic                      stat_mem_pkt_ready_i
);

  localparam int words_lp         = block_width_p / dword_width_p;
  localparam int dword_off_lp     = $clog2(dword_width_p/8);
  localparam int dword_sel_w_lp   = offset_width_lp - dword_off_lp;

  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_WAIT_META = 3'd1,
    ST_SEND_CMD  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_FILL_DATA = 3'd4,
    ST_FILL_TAG  = 3'd5,
    ST_FILL_STAT = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  state_e                     state_q, state_d;
  logic [paddr_width_p-1:0]   addr_q, addr_d;
  logic                       uncached_q, uncached_d;
  logic [way_width_lp-1:0]    way_q, way_d;
  logic [block_width_p-1:0]   block_q, block_d;
  logic                       cmd_v_q, cmd_v_d;
  logic                       data_v_q, data_v_d;
  logic                       tag_v_q, tag_v_d;
  logic                       stat_v_q, stat_v_d;
  logic                       complete_q, complete_d;

  logic [words_lp-1:0][dword_width_p-1:0] block_words;
  logic [dword_sel_w_lp-1:0]              dword_sel;
  logic                                   unused_addr_bits;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    uncached_d = uncached_q;
    way_d      = way_q;
    block_d    = block_q;
    unique case (state_q)
      ST_READY: begin
        if (cache_req_v_i) begin
          addr_d     = cache_req_addr_i;
          uncached_d = cache_req_uncached_i;
          if (cache_req_metadata_v_i) way_d = cache_req_metadata_way_i;
          // Uncached loads never touch a victim way, so they skip the metadata wait.
          state_d = (cache_req_metadata_v_i || cache_req_uncached_i) ? ST_SEND_CMD : ST_WAIT_META;
        end
      end
      ST_WAIT_META: begin
        if (cache_req_metadata_v_i) begin
          way_d   = cache_req_metadata_way_i;
          state_d = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD:  if (mem_cmd_ready_i) state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (mem_resp_v_i) begin
          block_d = mem_resp_data_i;
          state_d = ST_FILL_DATA;
        end
      end
      ST_FILL_DATA: if (data_mem_pkt_ready_i) state_d = uncached_q ? ST_DONE : ST_FILL_TAG;
      ST_FILL_TAG:  if (tag_mem_pkt_ready_i) state_d = ST_FILL_STAT;
      ST_FILL_STAT: if (stat_mem_pkt_ready_i) state_d = ST_DONE;
      ST_DONE:      state_d = ST_READY;
      default:      state_d = ST_READY;
    endcase

    cmd_v_d    = (state_d == ST_SEND_CMD);
    data_v_d   = (state_d == ST_FILL_DATA);
    tag_v_d    = (state_d == ST_FILL_TAG);
    stat_v_d   = (state_d == ST_FILL_STAT);
    complete_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_READY;
      addr_q     <= '0;
      uncached_q <= 1'b0;
      way_q      <= '0;
      block_q    <= '0;
      cmd_v_q    <= 1'b0;
      data_v_q   <= 1'b0;
      tag_v_q    <= 1'b0;
      stat_v_q   <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      uncached_q <= uncached_d;
      way_q      <= way_d;
      block_q    <= block_d;
      cmd_v_q    <= cmd_v_d;
      data_v_q   <= data_v_d;
      tag_v_q    <= tag_v_d;
      stat_v_q   <= stat_v_d;
      complete_q <= complete_d;
    end
  end

  assign block_words      = block_q;
  assign dword_sel        = addr_q[offset_width_lp-1:dword_off_lp];
  assign unused_addr_bits = ^addr_q[dword_off_lp-1:0];

  // Ready is forced low for the whole time reset is held, not just after an edge.
  assign cache_req_ready_o    = (state_q == ST_READY) & reset_n_i;
  assign cache_req_complete_o = complete_q;

  assign mem_cmd_addr_o  = {addr_q[paddr_width_p-1:offset_width_lp], {offset_width_lp{1'b0}}};
  assign mem_cmd_v_o     = cmd_v_q;
  assign mem_resp_yumi_o = (state_q == ST_WAIT_RESP) & mem_resp_v_i;

  assign data_mem_pkt_uncached_o = uncached_q;
  assign data_mem_pkt_index_o    = addr_q[offset_width_lp +: index_width_lp];
  assign data_mem_pkt_way_o      = way_q;
  assign data_mem_pkt_data_o     = uncached_q
                                 ? {{(block_width_p-dword_width_p){1'b0}}, block_words[dword_sel]}
                                 : block_q;
  assign data_mem_pkt_v_o        = data_v_q;

  assign tag_mem_pkt_index_o = addr_q[offset_width_lp +: index_width_lp];
  assign tag_mem_pkt_way_o   = way_q;
  assign tag_mem_pkt_tag_o   = addr_q[paddr_width_p-1:offset_width_lp+index_width_lp];
  assign tag_mem_pkt_v_o     = tag_v_q;

  assign stat_mem_pkt_index_o = addr_q[offset_width_lp +: index_width_lp];
  assign stat_mem_pkt_way_o   = way_q;
  assign stat_mem_pkt_v_o     = stat_v_q;

endmodule
`default_nettype wire

// File: doc/bp_fe_lce_responder.md
Name: bp_fe_lce_responder

Overview:
- Services instruction-cache misses raised by the front end.
- Accepts a cache request plus its victim-way metadata, fetches the block from a single-outstanding memory port, then writes the cache through the data, tag and stat packet ports.
- Pulses completion when the work is done.
- Sits between the front-end cache and the memory side; it is the responder for the front end's cache_req/mem_pkt interface.

Parameters:
paddr_width_p, 40, physical address width
lce_sets_p, 64, cache sets; index_width = clog2(lce_sets_p) = 6
lce_assoc_p, 8, ways; way_width = clog2(lce_assoc_p) = 3
block_width_p, 512, cache block bits; block offset = clog2(block_width_p/8) = 6
dword_width_p, 64, uncached return width
Derived: tag_width = paddr_width_p - index_width - block offset = 28

Ports:
clk_i  in  1  clock, all state on rising edge
reset_n_i  in  1  reset; asynchronous and active-low
cache_req_addr_i  in  paddr_width_p  miss address
cache_req_uncached_i  in  1  1 = uncached dword load, 0 = block miss
cache_req_v_i  in  1  request valid
cache_req_ready_o  out  1  ready to accept a request
cache_req_metadata_way_i  in  way_width  victim way
cache_req_metadata_v_i  in  1  metadata valid
cache_req_complete_o  out  1  one-cycle completion pulse
mem_cmd_addr_o  out  paddr_width_p  block-aligned fetch address
mem_cmd_v_o  out  1  fetch valid
mem_cmd_ready_i  in  1  memory accepts fetch
mem_resp_data_i  in  block_width_p  returned block
mem_resp_v_i  in  1  response valid
mem_resp_yumi_o  out  1  response consumed
data_mem_pkt_uncached_o  out  1  0 = block fill, 1 = uncached dword return
data_mem_pkt_index_o  out  index_width  set
data_mem_pkt_way_o  out  way_width  way
data_mem_pkt_data_o  out  block_width_p  block; for uncached, the dword sits in bits [63:0] and the rest is zero
data_mem_pkt_v_o  out  1  valid
data_mem_pkt_ready_i  in  1  ready
tag_mem_pkt_index_o  out  index_width  set
tag_mem_pkt_way_o  out  way_width  way
tag_mem_pkt_tag_o  out  tag_width  tag
tag_mem_pkt_v_o  out  1  valid (state is written as valid)
tag_mem_pkt_ready_i  in  1  ready
stat_mem_pkt_index_o  out  index_width  set
stat_mem_pkt_way_o  out  way_width  way to mark MRU
stat_mem_pkt_v_o  out  1  valid
stat_mem_pkt_ready_i  in  1  ready

Behaviour:
- Reset (reset_n_i low, asynchronous): FSM goes to READY. All valid outputs, cache_req_complete_o and mem_resp_yumi_o are 0. Latched registers clear to 0. cache_req_ready_o is 0 while reset is asserted and 1 in READY afterwards.
- Reset mid-operation abandons the transaction with no further packets. Memory-side cleanup is the system's responsibility.
- All handshakes are valid/ready. A transfer occurs when valid & ready on the same edge. Once asserted, a valid and its payload stay stable until the transfer.
- FSM states: READY, WAIT_META, SEND_CMD, WAIT_RESP, FILL_DATA, FILL_TAG, FILL_STAT, DONE.
- READY: cache_req_ready_o = 1. On cache_req_v_i, latch addr and uncached flag.
  - If metadata_v_i is asserted the same cycle, or the request is uncached, go to SEND_CMD. Latch the way when metadata is valid.
  - Otherwise go to WAIT_META.
- WAIT_META: cache_req_ready_o = 0. On metadata_v_i, latch the way and go to SEND_CMD. Metadata outside READY/WAIT_META is ignored.
- SEND_CMD: mem_cmd_v_o = 1, mem_cmd_addr_o = latched addr with the low 6 bits zeroed. Go to WAIT_RESP on mem_cmd_ready_i.
- WAIT_RESP: on mem_resp_v_i, assert mem_resp_yumi_o combinationally in the same cycle, latch the block, and go to FILL_DATA.
- FILL_DATA: data_mem_pkt_v_o = 1. Index = addr[11:6], way = latched way.
  - Uncached: data = dword selected by addr[5:3], zero-extended, with uncached flag = 1. On transfer go to DONE.
  - Cached: on transfer go to FILL_TAG.
- FILL_TAG: tag_mem_pkt_v_o = 1, tag = addr[39:12]. On transfer go to FILL_STAT.
- FILL_STAT: stat_mem_pkt_v_o = 1. On transfer go to DONE.
- DONE: cache_req_complete_o = 1 for exactly one cycle, then READY. A new request is accepted no earlier than the cycle after DONE.
- At most one packet valid is high at a time. Ports not being driven hold 0 valid; their payloads are don't-care.
- Minimum cached latency from request accept to complete pulse, with all readies high and a 1-cycle memory: 6 cycles (SEND_CMD, WAIT_RESP, FILL_DATA, FILL_TAG, FILL_STAT, DONE).

Test Plan:
- Cached miss, addr 0x00_1234_5678, metadata way 5 in the same cycle, all readies 1, resp one cycle after cmd -> mem_cmd_addr 0x0012345640; data pkt index 0x19 way 5; tag pkt tag 0x0012345 way 5; stat pkt way 5; complete pulses 6 cycles after accept.
- Metadata arrives 3 cycles after the request (way 2) -> cache_req_ready_o low in WAIT_META; SEND_CMD starts the cycle after metadata; all packets carry way 2.
- Uncached addr 0x80000018, block with dword i = i -> one data pkt, uncached = 1, data[63:0] = 3, upper bits 0; no tag/stat valids; single complete pulse.
- Backpressure: data_mem_pkt_ready_i held low 4 cycles, tag ready low 2 cycles -> valids and payloads stable throughout; each packet transfers exactly once; order is data, tag, stat.
- reset_n_i dropped during WAIT_RESP -> all valids 0 immediately (asynchronously); after release, ready = 1 and a new request completes normally with no stale packets.
- Back-to-back requests with cache_req_v_i held high -> second accepted the cycle after the DONE pulse; exactly two complete pulses.
